// File: rtl/fwd_scoreboard_unit.sv
// fwd_scoreboard_unit: operand forwarding selects, long-latency register
// scoreboard, load-use / RAW / WAW / structural stall generation and a
// saturating stall-cycle performance counter for the RV32IM pipeline.
module fwd_scoreboard_unit #(
    parameter int NUM_SRC    = 3,
    parameter int AW         = 5,
    parameter int NUM_REGS   = 32,
    parameter int FWD_STAGES = 2,
    parameter int MAX_OUT    = 4,
    parameter int CNT_W      = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_SRC*AW-1:0]                     rs_addr_id_i,
    input  logic [NUM_SRC-1:0]                        rs_used_id_i,
    input  logic [NUM_SRC*AW-1:0]                     rs_addr_ex_i,
    input  logic                                      rd_we_ex_i,
    input  logic                                      mem_read_ex_i,
    input  logic [AW-1:0]                             rd_addr_ex_i,
    input  logic                                      rd_we_id_i,
    input  logic [AW-1:0]                             rd_addr_id_i,
    input  logic [FWD_STAGES-1:0]                     rd_we_stg_i,
    input  logic [FWD_STAGES*AW-1:0]                  rd_addr_stg_i,
    input  logic                                      lat_issue_i,
    input  logic                                      lat_done_i,
    input  logic [AW-1:0]                             lat_done_rd_i,
    input  logic                                      flush_i,
    output logic [NUM_SRC*$clog2(FWD_STAGES+1)-1:0]   alu_forward_o,
    output logic [NUM_SRC-1:0]                        branch_forward_o,
    output logic                                      stall_o,
    output logic [NUM_REGS-1:0]                       pending_o,
    output logic [$clog2(MAX_OUT+1)-1:0]              outstanding_o,
    output logic                                      err_o,
    output logic [CNT_W-1:0]                          stall_cnt_o
);

    localparam int SEL_W = $clog2(FWD_STAGES + 1);
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [OUT_W-1:0]    outstanding_q, outstanding_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic [NUM_REGS-1:0] pending_eff;
    logic                load_use, raw_hit, waw_hit, struct_hit, stall_raw;
    logic                done_ok, issue_ok;

    // EX forwarding: the nearest stage that writes the source register wins.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        alu_forward_o = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int j = FWD_STAGES - 1; j >= 0; j--) begin
                if (rd_we_stg_i[j] &&
                    rd_addr_stg_i[j*AW +: AW] == rs_addr_ex_i[s*AW +: AW] &&
                    rd_addr_stg_i[j*AW +: AW] != '0) begin
                    alu_forward_o[s*SEL_W +: SEL_W] = SEL_W'(j + 1);
                end
            end
        end
    end

    // Branch forwarding from the MEM stage into ID comparators.
    always_comb begin
        branch_forward_o = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            branch_forward_o[s] = rd_we_stg_i[0] &&
                                  rd_addr_stg_i[0 +: AW] == rs_addr_id_i[s*AW +: AW] &&
                                  rd_addr_stg_i[0 +: AW] != '0;
        end
    end

    // Hazard detection; a completion this cycle hides its register from the checks.
    always_comb begin
        pending_eff = pending_q;
        if (lat_done_i) begin
            pending_eff[lat_done_rd_i] = 1'b0;
        end
        load_use = 1'b0;
        raw_hit  = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (rs_used_id_i[s]) begin
                if (mem_read_ex_i && rd_we_ex_i && rd_addr_ex_i != '0 &&
                    rs_addr_id_i[s*AW +: AW] == rd_addr_ex_i) begin
                    load_use = 1'b1;
                end
                if (pending_eff[rs_addr_id_i[s*AW +: AW]]) begin
                    raw_hit = 1'b1;
                end
            end
        end
        waw_hit    = (rd_we_id_i || lat_issue_i) && pending_eff[rd_addr_id_i];
        struct_hit = lat_issue_i && (outstanding_q == OUT_W'(MAX_OUT));
        stall_raw  = load_use || raw_hit || waw_hit || struct_hit;
        // Stall is forced low while reset is held.
        stall_o    = rst && stall_raw;
    end

    // Next-state for scoreboard, outstanding count, error flag and counter.
    always_comb begin
        done_ok  = lat_done_i && pending_q[lat_done_rd_i];
        issue_ok = lat_issue_i && !stall_o && !flush_i && rd_addr_id_i != '0;

        pending_d = pending_q;
        if (done_ok) begin
            pending_d[lat_done_rd_i] = 1'b0;
        end
        // Issue is applied after completion so a same-register set wins.
        if (issue_ok) begin
            pending_d[rd_addr_id_i] = 1'b1;
        end
        pending_d[0] = 1'b0;

        outstanding_d = outstanding_q;
        if (issue_ok && !done_ok && outstanding_q != OUT_W'(MAX_OUT)) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (done_ok && !issue_ok && outstanding_q != '0) begin
            outstanding_d = outstanding_q - 1'b1;
        end

        err_d = err_q || (lat_done_i && !done_ok);

        stall_cnt_d = stall_cnt_q;
        if (stall_o && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q     <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign pending_o     = pending_q;
    assign outstanding_o = outstanding_q;
    assign err_o         = err_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: doc/fwd_scoreboard_unit.md
Name: fwd_scoreboard_unit

Overview:
- Parametrised successor of the pipeline forwarding unit for the RV32IM core.
- Generalises operand count and number of forwarding stages.
- Adds a register scoreboard for long-latency M-extension ops (div/rem), load-use detection and stall generation.
- Sits between ID/EX control and the hazard-stall path.
- Forwarding selects are combinational; scoreboard, outstanding counter, error flag and stall counter are sequential.

Parameters:
- NUM_SRC, 3, number of source operands per instruction (rs1..rsN).
- AW, 5, register address width.
- NUM_REGS, 32, architectural registers (2**AW).
- FWD_STAGES, 2, forwarding stages after EX; index 0 = MEM (nearest), index 1 = WB.
- MAX_OUT, 4, maximum outstanding long-latency ops.
- SEL_W, $clog2(FWD_STAGES+1), forward select width (derived; not overridden).
- CNT_W, 16, stall performance counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rs_addr_id_i  in  NUM_SRC*AW  ID-stage source addresses, packed, src0 in LSBs.
- rs_used_id_i  in  NUM_SRC  ID source-valid mask.
- rs_addr_ex_i  in  NUM_SRC*AW  EX-stage source addresses.
- rd_we_ex_i  in  1  EX instruction writes rd.
- mem_read_ex_i  in  1  EX instruction is a load.
- rd_addr_ex_i  in  AW  EX destination.
- rd_we_id_i  in  1  ID instruction writes rd (short latency).
- rd_addr_id_i  in  AW  ID destination.
- rd_we_stg_i  in  FWD_STAGES  per-stage write enable.
- rd_addr_stg_i  in  FWD_STAGES*AW  per-stage destination.
- lat_issue_i  in  1  ID instruction is a long-latency op writing rd_addr_id_i.
- lat_done_i  in  1  long-latency result written back this cycle.
- lat_done_rd_i  in  AW  destination of completed op.
- flush_i  in  1  kill ID instruction (no issue).
- alu_forward_o  out  NUM_SRC*SEL_W  per EX source: 0 = regfile, k = stage k-1.
- branch_forward_o  out  NUM_SRC  per ID source: forward from MEM.
- stall_o  out  1  hold IF/ID, bubble EX.
- pending_o  out  NUM_REGS  scoreboard bits.
- outstanding_o  out  $clog2(MAX_OUT+1)  live long-latency count.
- err_o  out  1  sticky protocol error.
- stall_cnt_o  out  CNT_W  saturating stall-cycle count.

Behaviour:
- Reset (rst=0, asynchronous):
  - pending_o=0, outstanding_o=0, err_o=0, stall_cnt_o=0.
  - stall_o=0 regardless of inputs.
  - Other outputs are combinational and follow their inputs.
- EX forwarding (combinational):
  - For source s, select the lowest-index stage j with rd_we_stg_i[j], rd_addr_stg_i[j]==rs_addr_ex_s and rd_addr!=0; output j+1.
  - Otherwise output 0. Values above FWD_STAGES never appear.
- Branch forwarding (combinational):
  - branch_forward_o[s] = rd_we_stg_i[0] && rd_addr_stg_i[0]==rs_addr_id_s && rd_addr_stg_i[0]!=0.
- Stall sources (OR-ed; any one asserts stall_o):
  - Load-use: mem_read_ex_i && rd_we_ex_i && rd_addr_ex_i!=0 && some used ID source equals rd_addr_ex_i.
  - RAW: any used ID source s with pending[rs_s]=1.
  - WAW: (rd_we_id_i || lat_issue_i) && pending[rd_addr_id_i].
  - Structural: lat_issue_i && outstanding_o==MAX_OUT.
  - Same-cycle completion: lat_done_i clears pending before the RAW check, so a source whose op completes this cycle does not stall.
- Issue accepted when: lat_issue_i && !stall_o && !flush_i && rd_addr_id_i!=0.
  - Sets pending[rd] and increments outstanding.
  - lat_issue_i with rd=x0 is accepted but leaves pending and outstanding unchanged.
- Completion (lat_done_i):
  - If pending[lat_done_rd_i]: clear it and decrement outstanding.
  - If not pending (or x0): no state change, err_o<=1.
- Simultaneous completion and accepted issue:
  - Outstanding net unchanged.
  - Same register: pending ends 1 (set wins).
- pending[0] is hardwired 0.
- outstanding never exceeds MAX_OUT and never underflows.
- stall_cnt_o increments each cycle stall_o=1 and saturates at all-ones.
- flush_i does not clear the scoreboard; in-flight ops still complete.

Test Plan:
- Reset sequence: rst low mid-operation with pending_o=0x0000_0020 -> all state 0 asynchronously; stall_o=0.
- Forward priority: rs_addr_ex src0=7, stage0 and stage1 both write x7 -> alu_forward src0=1; disable stage0 -> 2; rd=x0 on both -> 0.
- Load-use: EX load to x5, ID rs2=x5 used -> stall_o=1 for 1 cycle; same with rs_used bit clear -> stall_o=0.
- Scoreboard RAW: issue div x9; ID reads x9 for 10 cycles -> stall_o=1 for 10 cycles; lat_done_rd=9 -> stall_o=0 that cycle, pending[9]=0, stall_cnt_o=10.
- Structural and error: 4 issues to x1..x4 -> outstanding=4; fifth issue stalls. Done on x6 (not pending) -> err_o=1 and stays 1.
- Simultaneous events: done x3 and issue x3 in the same cycle -> pending[3]=1, outstanding unchanged. Flushed issue -> no pending set.
